mem_access_ctrl: RTL and testbench

Memory access initiator for the 8-bit processor's data memory. It accepts single-byte load and store requests and multi-byte block copy and fill requests from the core through a valid/ready handshake. It drives the data memory's address, read strobe, write strobe and write data, and it absorbs the memory's one-cycle registered read latency. It returns a one-cycle response pulse with the read or last-copied byte.

---
 rtl/mem_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory access initiator: single-byte load/store plus block copy/fill,
// absorbing the memory's one-cycle registered read latency.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [7:0]        req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LEN_W = 8;

  typedef enum logic [2:0] {IDLE, RD, XFER, CAP, WR, DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_COPY, OP_FILL} op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d, req_op_e;
  logic              go_q, go_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [DATA_W-1:0] rdata_d;
  logic              accept;
  logic              ready_d, rd_d, wr_d, resp_valid_d;
  logic [ADDR_W-1:0] addr_d;

  assign req_op_e = op_t'(req_op);
  assign accept   = req_valid && req_ready;

  // The accept cycle only latches the request; the operation starts one edge later
  always_comb begin
    state_d = state_q;
    go_d    = 1'b0;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    rdata_d = resp_rdata;
    unique case (state_q)
      IDLE: begin
        if (go_q) begin
          unique case (op_q)
            OP_LOAD:  state_d = RD;
            OP_STORE: state_d = WR;
            OP_COPY:  state_d = (cnt_q == '0) ? DONE : RD;
            OP_FILL:  state_d = (cnt_q == '0) ? DONE : WR;
          endcase
        end else if (accept) begin
          go_d  = 1'b1;
          op_d  = req_op_e;
          src_d = req_addr;
          dst_d = (req_op_e == OP_COPY) ? req_dst : req_addr;
          cnt_d = req_len;
          pat_d = req_wdata;
        end
      end
      RD:   state_d = (op_q == OP_COPY) ? XFER : CAP;
      CAP: begin
        rdata_d = mem_rdata;
        state_d = DONE;
      end
      XFER: begin
        rdata_d = mem_rdata;
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? DONE : RD;
      end
      WR: begin
        if (op_q == OP_FILL) begin
          dst_d   = dst_q + ADDR_W'(1);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? DONE : WR;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from next state so they can be flopped
  always_comb begin
    ready_d      = (state_d == IDLE) && !go_d;
    rd_d         = (state_d == RD);
    wr_d         = (state_d == WR) || (state_d == XFER);
    resp_valid_d = (state_d == DONE);
    addr_d       = '0;
    if (rd_d) begin
      addr_d = src_d;
    end else if (wr_d) begin
      addr_d = dst_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      go_q        <= 1'b0;
      op_q        <= OP_LOAD;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      pat_q       <= '0;
      resp_rdata  <= '0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      resp_rdata  <= rdata_d;
      req_ready   <= ready_d;
      busy        <= !ready_d;
      resp_valid  <= resp_valid_d;
      mem_read    <= rd_d;
      mem_write   <= wr_d;
      mem_address <= addr_d;
    end
  end

  // Copy writes the byte the memory is returning this cycle, so write data bypasses the flops
  always_comb begin
    mem_wdata = '0;
    if (state_q == XFER) begin
      mem_wdata = mem_rdata;
    end else if (state_q == WR) begin
      mem_wdata = pat_q;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a registered-read memory model and
// a reference memory/response scoreboard.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr, req_dst, req_len, req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       busy;
  logic [7:0] mem_address;
  logic       mem_read, mem_write;
  logic [7:0] mem_wdata, mem_rdata;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;
  logic [7:0] exp_rdata;

  typedef struct {
    logic [7:0] rdata;
    int         cyc;
    int         nrd;
    int         nwr;
    int         first;
    int         last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_dst     (req_dst),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .busy        (busy),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory with a one-cycle registered read and a backdoor preload port
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write) mem[mem_address] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input logic [7:0] a0, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = a0 + 8'(i);
      chk($sformatf("mem[%02h]", a), 32'(mem[a]), 32'(ref_mem[a]));
    end
  endtask

  // Issue one request, predict its outcome, watch the DUT until the response
  task automatic do_req(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] dst,
                        input logic [7:0] len, input logic [7:0] wdata, input bit hold);
    exp_t       e, got;
    logic [7:0] a, d, b, rd_obs;
    int nrd, nwr, first_s, last_s, overlap, idle_bad, bsy_bad, resp_cyc;
    e.nrd = 0; e.nwr = 0; e.first = -1; e.last = -1; e.cyc = 1;
    case (op)
      2'b00: begin
        exp_rdata = ref_mem[addr];
        e.cyc = 3; e.nrd = 1; e.first = 1; e.last = 1;
      end
      2'b01: begin
        ref_mem[addr] = wdata;
        e.cyc = 2; e.nwr = 1; e.first = 1; e.last = 1;
      end
      2'b10: if (len != 0) begin
        for (int i = 0; i < int'(len); i++) begin
          a = addr + 8'(i);
          d = dst + 8'(i);
          b = ref_mem[a];
          ref_mem[d] = b;
          exp_rdata = b;
        end
        e.cyc = 2 * int'(len) + 1; e.nrd = int'(len); e.nwr = int'(len);
        e.first = 1; e.last = 2 * int'(len);
      end
      default: if (len != 0) begin
        for (int i = 0; i < int'(len); i++) begin
          a = addr + 8'(i);
          ref_mem[a] = wdata;
        end
        e.cyc = int'(len) + 1; e.nwr = int'(len); e.first = 1; e.last = int'(len);
      end
    endcase
    e.rdata = exp_rdata;
    sb.push_back(e);

    @(negedge clk);
    req_op = op; req_addr = addr; req_dst = dst; req_len = len; req_wdata = wdata;
    req_valid = 1'b1;
    nrd = 0; nwr = 0; first_s = -1; last_s = -1; overlap = 0; idle_bad = 0; bsy_bad = 0;
    resp_cyc = -1; rd_obs = 8'h00;
    for (int k = 0; k < 600 && resp_cyc < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("ready_low_after_accept", 32'(req_ready), 32'(0));
        if (hold) begin
          req_op = op ^ 2'b01; req_addr = addr + 8'h80; req_dst = dst + 8'h80;
          req_wdata = ~wdata;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (mem_read && mem_write) overlap++;
      if (!mem_read && !mem_write && (mem_address != 8'h00 || mem_wdata != 8'h00)) idle_bad++;
      if (busy !== !req_ready) bsy_bad++;
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (mem_read || mem_write) begin
        if (first_s < 0) first_s = k;
        last_s = k;
      end
      if (resp_valid) begin
        resp_cyc = k;
        rd_obs = resp_rdata;
      end
    end
    chk("resp_seen", 32'(resp_cyc >= 0), 32'(1));
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("resp_cycle", 32'(resp_cyc), 32'(got.cyc));
      chk("resp_rdata", 32'(rd_obs), 32'(got.rdata));
      chk("read_count", 32'(nrd), 32'(got.nrd));
      chk("write_count", 32'(nwr), 32'(got.nwr));
      chk("first_strobe", 32'(first_s), 32'(got.first));
      chk("last_strobe", 32'(last_s), 32'(got.last));
    end
    chk("strobe_overlap", 32'(overlap), 32'(0));
    chk("idle_bus_nonzero", 32'(idle_bad), 32'(0));
    chk("busy_vs_ready", 32'(bsy_bad), 32'(0));
    @(negedge clk);
    chk("single_resp", 32'(resp_valid), 32'(0));
    chk("ready_after_done", 32'(req_ready), 32'(1));
    req_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbad;
    int nresp;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 8'h00; req_dst = 8'h00;
    req_len = 8'h00; req_wdata = 8'h00; pl_en = 1'b1; pl_addr = 8'h00; pl_data = 8'h00;
    exp_rdata = 8'h00;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pl_addr = 8'(i);
      pl_data = (i == 0) ? 8'h4B : (i == 1) ? 8'h07 : (i == 2) ? 8'h5E : 8'(i * 7 + 3);
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;

    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_resp_rdata", 32'(resp_rdata), 32'(0));
    chk("rst_mem_read", 32'(mem_read), 32'(0));
    chk("rst_mem_write", 32'(mem_write), 32'(0));
    chk("rst_mem_address", 32'(mem_address), 32'(0));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'(1));

    do_req(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    do_req(2'b01, 8'h20, 8'h99, 8'h00, 8'hA5, 1'b0);
    chk_mem(8'h20, 1);
    do_req(2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0);

    // copy while the core keeps presenting a different op
    do_req(2'b10, 8'h00, 8'h40, 8'd3, 8'h00, 1'b1);
    chk_mem(8'h40, 3);
    nresp = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("no_queued_request", 32'(nresp), 32'(0));

    do_req(2'b11, 8'hFE, 8'h00, 8'd4, 8'h3C, 1'b0);
    chk_mem(8'hFC, 8);
    do_req(2'b10, 8'h00, 8'h50, 8'd0, 8'h00, 1'b0);
    do_req(2'b11, 8'h60, 8'h00, 8'd0, 8'h99, 1'b0);
    chk_mem(8'h60, 1);

    // overlapping ascending copy smears the first source byte forward
    do_req(2'b10, 8'h40, 8'h41, 8'd3, 8'h00, 1'b0);
    chk_mem(8'h40, 4);

    // reset in the middle of a fill
    @(negedge clk);
    req_op = 2'b11; req_addr = 8'h10; req_dst = 8'h00; req_len = 8'd6; req_wdata = 8'h77;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    nresp = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("fill_c3_write", 32'(mem_write), 32'(1));
    chk("fill_c3_address", 32'(mem_address), 32'(8'h12));
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_mem_write", 32'(mem_write), 32'(0));
    chk("midrst_mem_address", 32'(mem_address), 32'(0));
    chk("midrst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("midrst_resp_rdata", 32'(resp_rdata), 32'(0));
    ref_mem[8'h10] = 8'h77;
    ref_mem[8'h11] = 8'h77;
    exp_rdata = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("midrst_no_resp", 32'(nresp), 32'(0));
    chk_mem(8'h10, 6);
    do_req(2'b00, 8'h12, 8'h00, 8'h00, 8'h00, 1'b0);
    do_req(2'b00, 8'h11, 8'h00, 8'h00, 8'h00, 1'b0);

    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) nbad++;
    end
    chk("mem_all_addresses", 32'(nbad), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
